// File: rtl/rectangle_pkg.sv
// Shared S-box tables, FSM state encoding and lookup helper for the
// column-serial substitution layer.
package rectangle_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Entry i lives in nibble i (entry 0 is the least significant nibble).
  localparam logic [15:0][3:0] SBOX_FWD = 64'h24F8_D30B_97E1_AC56;
  localparam logic [15:0][3:0] SBOX_INV = 64'hD5B2_837C_601E_AF49;

  function automatic logic [3:0] sbox_lookup(input logic [3:0] nib, input logic inv);
    return inv ? SBOX_INV[nib] : SBOX_FWD[nib];
  endfunction

endpackage

// File: rtl/sub_column_serial_sbox.sv
// One 4-bit S-box that serves both directions; i_dec selects the inverse table.
module sbox_enc_dec
  import rectangle_pkg::*;
(
  input  logic [3:0] i_nib,
  input  logic       i_dec,
  output logic [3:0] o_nib
);

  always_comb begin
    o_nib = sbox_lookup(i_nib, i_dec);
  end

endmodule

// File: rtl/sub_column_serial.sv
// Column-serial S-box layer: LANES columns substituted per cycle, in place,
// with a ready/valid handshake on both sides.
module sub_column_serial
  import rectangle_pkg::*;
#(
  parameter int COLS  = 16,
  parameter int LANES = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [4*COLS-1:0] in_state,
  input  logic              dec,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [4*COLS-1:0] out_state
);

  localparam int GROUPS = COLS / LANES;
  localparam int CW     = (GROUPS > 1) ? $clog2(GROUPS) : 1;
  localparam int IW     = (COLS > 1) ? $clog2(COLS) : 1;
  localparam logic [CW-1:0] LAST = CW'(GROUPS - 1);

  if (COLS % LANES != 0) begin : g_bad_lanes
    $error("sub_column_serial: LANES must divide COLS");
  end

  state_e                       r_fsm;
  logic [CW-1:0]                r_cnt;
  logic                         r_dec;
  logic [3:0][COLS-1:0]         r_state;

  logic [IW-1:0]                w_base;
  logic [LANES-1:0][IW-1:0]     w_col;
  logic [LANES-1:0][3:0]        w_nib_in;
  logic [LANES-1:0][3:0]        w_nib_out;
  logic [3:0][COLS-1:0]         w_next;

  // Base column of the current group; cnt is zero whenever LANES == COLS,
  // so truncating LANES into IW bits cannot change the product.
  assign w_base = IW'(r_cnt) * IW'(LANES);

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    assign w_col[l]    = w_base + IW'(l);
    assign w_nib_in[l] = {r_state[3][w_col[l]], r_state[2][w_col[l]],
                          r_state[1][w_col[l]], r_state[0][w_col[l]]};
    sbox_enc_dec u_sbox (
      .i_nib (w_nib_in[l]),
      .i_dec (r_dec),
      .o_nib (w_nib_out[l])
    );
  end

  always_comb begin
    w_next = r_state;
    for (int l = 0; l < LANES; l++) begin
      for (int r = 0; r < 4; r++) begin
        w_next[r][w_col[l]] = w_nib_out[l][r];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_fsm   <= ST_IDLE;
      r_cnt   <= '0;
      r_dec   <= 1'b0;
      r_state <= '0;
    end else begin
      case (r_fsm)
        ST_IDLE: begin
          if (in_valid) begin
            r_state <= in_state;
            r_dec   <= dec;
            r_cnt   <= '0;
            r_fsm   <= ST_BUSY;
          end
        end
        ST_BUSY: begin
          r_state <= w_next;
          // cnt parks on the last group so it never exceeds GROUPS-1
          if (r_cnt == LAST) begin
            r_fsm <= ST_DONE;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        ST_DONE: begin
          if (out_ready) begin
            r_fsm <= ST_IDLE;
          end
        end
        default: r_fsm <= ST_IDLE;
      endcase
    end
  end

  assign in_ready  = (r_fsm == ST_IDLE);
  assign out_valid = (r_fsm == ST_DONE);
  assign out_state = r_state;

endmodule
